// File: rtl/vend_pkg.sv
// vend_pkg: state encoding and widths shared by the vending credit and dispense controllers
package vend_pkg;

    localparam int CREDIT_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        VEND,
        CHG_HI,
        CHG_LO,
        DENY
    } vend_state_t;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_rise_det.sv
// sync_rise_det: two-flop synchronizer for an asynchronous input plus a one-cycle rising-edge pulse
module sync_rise_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o
);

    logic s1_q, s2_q, prev_q;

    // Synchronizer chain; prev_q keeps tracking so a held input yields a single pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= d_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign rise_o = s2_q & ~prev_q;

endmodule

// File: rtl/vend_dispense_ctrl.sv
// vend_dispense_ctrl: runs the dispense motor and returns change, or flashes deny, on each BUY press
module vend_dispense_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE        = 2,
    parameter int DISP_CYCLES  = 16,
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 4,
    parameter int DENY_CYCLES  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CREDIT_W-1:0] credit_i,
    input  logic                buy_raw_i,
    output logic                clear_credit_o,
    output logic                dispense_o,
    output logic                change_pulse_o,
    output logic                deny_o,
    output logic                busy_o
);

    localparam int MAXC = max_of(max_of(DISP_CYCLES, PULSE_CYCLES), max_of(GAP_CYCLES, DENY_CYCLES));
    localparam int TW   = $clog2(MAXC) + 1;
    localparam logic [TW-1:0]       T_DISP  = TW'(DISP_CYCLES - 1);
    localparam logic [TW-1:0]       T_PULSE = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0]       T_GAP   = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0]       T_DENY  = TW'(DENY_CYCLES - 1);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    if (PRICE < 1 || PRICE > 3) begin : g_bad_price
        $error("vend_dispense_ctrl: PRICE must be in 1..3");
    end
    if (DISP_CYCLES < 1 || PULSE_CYCLES < 1 || GAP_CYCLES < 1 || DENY_CYCLES < 1) begin : g_bad_cycles
        $error("vend_dispense_ctrl: cycle parameters must be >= 1");
    end

    vend_state_t         state_q, state_d;
    logic [TW-1:0]       tmr_q, tmr_d;
    logic [CREDIT_W-1:0] chg_q, chg_d;
    logic                buy_edge;
    logic                clear_d, dispense_d, change_d, deny_d, busy_d;

    sync_rise_det u_buy_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (buy_raw_i),
        .rise_o (buy_edge)
    );

    // State, timer and pending-change registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            chg_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            chg_q   <= chg_d;
        end
    end

    // Next state: credit is sampled only when a vend is committed; buy edges outside IDLE are dropped
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        chg_d   = chg_q;
        case (state_q)
            IDLE: begin
                if (buy_edge && credit_i >= PRICE_C) begin
                    state_d = VEND;
                    chg_d   = credit_i - PRICE_C;
                    tmr_d   = T_DISP;
                end else if (buy_edge) begin
                    state_d = DENY;
                    tmr_d   = T_DENY;
                end
            end
            VEND: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - 1'b1;
                end else begin
                    state_d = (chg_q != '0) ? CHG_HI : IDLE;
                    tmr_d   = T_PULSE;
                end
            end
            CHG_HI: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - 1'b1;
                end else begin
                    state_d = CHG_LO;
                    chg_d   = chg_q - 1'b1;
                    tmr_d   = T_GAP;
                end
            end
            CHG_LO: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - 1'b1;
                end else begin
                    state_d = (chg_q != '0) ? CHG_HI : IDLE;
                    tmr_d   = T_PULSE;
                end
            end
            DENY: begin
                if (tmr_q != '0) tmr_d = tmr_q - 1'b1;
                else             state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up with the state
    always_comb begin
        clear_d    = (state_q == IDLE) && (state_d == VEND);
        dispense_d = (state_d == VEND);
        change_d   = (state_d == CHG_HI);
        deny_d     = (state_d == DENY);
        busy_d     = (state_d != IDLE);
    end

    // Glitch-free registered outputs, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clear_credit_o <= 1'b0;
            dispense_o     <= 1'b0;
            change_pulse_o <= 1'b0;
            deny_o         <= 1'b0;
            busy_o         <= 1'b0;
        end else begin
            clear_credit_o <= clear_d;
            dispense_o     <= dispense_d;
            change_pulse_o <= change_d;
            deny_o         <= deny_d;
            busy_o         <= busy_d;
        end
    end

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// tb_vend_dispense_ctrl: two controllers (PRICE 2 and PRICE 1) against a timeline model of a vend
module tb_vend_dispense_ctrl;

    localparam int D  = 16;
    localparam int P  = 4;
    localparam int G  = 4;
    localparam int DN = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       buy   = 1'b0;
    logic [1:0] credit = 2'd0;
    logic       clr2, dis2, chg2, den2, bsy2;
    logic       clr1, dis1, chg1, den1, bsy1;
    logic [4:0] o2, o1;
    int         checks = 0;
    int         passes = 0;
    int         fails  = 0;

    always #5 clk = ~clk;

    vend_dispense_ctrl #(.PRICE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .credit_i(credit), .buy_raw_i(buy),
        .clear_credit_o(clr2), .dispense_o(dis2), .change_pulse_o(chg2), .deny_o(den2), .busy_o(bsy2)
    );

    vend_dispense_ctrl #(.PRICE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .credit_i(credit), .buy_raw_i(buy),
        .clear_credit_o(clr1), .dispense_o(dis1), .change_pulse_o(chg1), .deny_o(den1), .busy_o(bsy1)
    );

    assign o2 = {clr2, dis2, chg2, den2, bsy2};
    assign o1 = {clr1, dis1, chg1, den1, bsy1};

    // Expected {clear,dispense,change,deny,busy} j cycles after the edge where the press is first sampled
    function automatic logic [4:0] exp_out(input int cr, input int price, input int j);
        int u, r, n;
        u = j - 2;
        if (u < 0) return 5'b0;
        if (cr < price) return (u < DN) ? 5'b00011 : 5'b0;
        if (u < D) return {u == 0, 1'b1, 1'b0, 1'b0, 1'b1};
        r = u - D;
        n = cr - price;
        if (r < n * (P + G)) return {1'b0, 1'b0, (r % (P + G)) < P, 1'b0, 1'b1};
        return 5'b0;
    endfunction

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // One press held h cycles (optionally re-pressed while busy); fcr<0 randomizes credit every cycle
    task automatic run_txn(input string tag, input int h, input bit repress, input int fcr);
        logic [1:0] cr_at;
        int w;
        cr_at = 2'd0;
        w = ((h + 4) > 34 ? h + 4 : 34) + 6;
        for (int j = 0; j < w; j++) begin
            buy    = (j < h) || (repress && j >= h + 2 && j < h + 4);
            credit = (fcr < 0) ? 2'($urandom_range(0, 3)) : 2'(fcr);
            if (j == 2) cr_at = credit;
            @(posedge clk);
            #1;
            check({tag, "_p2"}, o2, exp_out(int'(cr_at), 2, j));
            check({tag, "_p1"}, o1, exp_out(int'(cr_at), 1, j));
        end
        buy = 1'b0;
    endtask

    initial begin
        #12;
        check("reset_p2", o2, 5'b0);
        check("reset_p1", o1, 5'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_txn("exact", 2, 1'b0, 2);
        run_txn("change", 2, 1'b0, 3);
        run_txn("deny", 2, 1'b0, 1);
        run_txn("zero", 1, 1'b0, 0);
        run_txn("held", 100, 1'b0, 3);
        run_txn("repress", 3, 1'b1, 2);
        run_txn("glitch1", 1, 1'b0, 3);
        for (int i = 0; i < 10; i++) begin
            int h;
            bit rp;
            h  = $urandom_range(1, 100);
            rp = (h <= 6) && ($urandom_range(0, 1) == 1);
            run_txn("rand", h, rp, -1);
        end
        // Reset in the first change pulse: outputs must drop without waiting for a clock
        credit = 2'd3;
        for (int j = 0; j < 20; j++) begin
            buy = (j < 2);
            @(posedge clk);
            #1;
            check("pre_rst_p2", o2, exp_out(3, 2, j));
            check("pre_rst_p1", o1, exp_out(3, 1, j));
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_p2", o2, 5'b0);
        check("rst_async_p1", o1, 5'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 40; j++) begin
            @(posedge clk);
            #1;
            check("post_rst_p2", o2, 5'b0);
            check("post_rst_p1", o1, 5'b0);
        end
        // Sub-cycle glitch that no clock edge sees
        #2;
        buy = 1'b1;
        #3;
        buy = 1'b0;
        for (int j = 0; j < 12; j++) begin
            @(posedge clk);
            #1;
            check("narrow_p2", o2, 5'b0);
            check("narrow_p1", o1, 5'b0);
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
